// File: rtl/i2c_reg_sequencer_pkg.sv
// rtl/i2c_reg_sequencer_pkg.sv - register map, command bits and per-phase byte tables for the sequencer
package i2c_reg_sequencer_pkg;

    localparam logic [2:0] ADR_PRER_LO = 3'd0;
    localparam logic [2:0] ADR_PRER_HI = 3'd1;
    localparam logic [2:0] ADR_CTR     = 3'd2;
    localparam logic [2:0] ADR_TXR     = 3'd3;
    localparam logic [2:0] ADR_RXR     = 3'd3;
    localparam logic [2:0] ADR_CR      = 3'd4;
    localparam logic [2:0] ADR_SR      = 3'd4;

    localparam logic [7:0] CR_STA = 8'h80;
    localparam logic [7:0] CR_STO = 8'h40;
    localparam logic [7:0] CR_RD  = 8'h20;
    localparam logic [7:0] CR_WR  = 8'h10;
    localparam logic [7:0] CR_ACK = 8'h08;

    localparam logic [7:0] CTR_EN  = 8'h80;
    localparam logic [7:0] CTR_OFF = 8'h00;

    localparam int SR_RXACK = 7;
    localparam int SR_TIP   = 1;

    typedef enum logic [3:0] {
        ST_INIT,
        ST_IDLE,
        ST_LOAD_TXR,
        ST_WRITE_CR,
        ST_POLL,
        ST_READ_RXR,
        ST_NACK_STOP,
        ST_ABORT,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic       rw;
        logic [6:0] dev;
        logic [7:0] addr;
        logic [7:0] wdata;
    } cmd_t;

    // Phase 2 differs by direction: a read re-addresses the device with a repeated start.
    function automatic logic [7:0] phase_txr(input cmd_t c, input logic [1:0] ph);
        logic [7:0] v;
        case (ph)
            2'd0:    v = {c.dev, 1'b0};
            2'd1:    v = c.addr;
            2'd2:    v = c.rw ? {c.dev, 1'b1} : c.wdata;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    function automatic logic [7:0] phase_cr(input cmd_t c, input logic [1:0] ph);
        logic [7:0] v;
        case (ph)
            2'd0:    v = CR_STA | CR_WR;
            2'd1:    v = CR_WR;
            2'd2:    v = c.rw ? (CR_STA | CR_WR) : (CR_WR | CR_STO);
            default: v = CR_RD | CR_ACK | CR_STO;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/i2c_reg_sequencer_if.sv
// rtl/i2c_reg_sequencer_if.sv - command/response and core-side Wishbone signal bundle
interface i2c_reg_sequencer_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rw;
    logic [6:0] cmd_dev;
    logic [7:0] cmd_reg;
    logic [7:0] cmd_wdata;

    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_nack;
    logic       rsp_timeout;
    logic       busy;

    logic [2:0] wb_adr_o;
    logic [7:0] wb_dat_o;
    logic [7:0] wb_dat_i;
    logic       wb_we_o;
    logic       wb_stb_o;
    logic       wb_cyc_o;
    logic       wb_ack_i;

    modport master (
        input  cmd_valid, cmd_rw, cmd_dev, cmd_reg, cmd_wdata, wb_dat_i, wb_ack_i,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_nack, rsp_timeout, busy,
               wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o
    );

    modport slave (
        output cmd_valid, cmd_rw, cmd_dev, cmd_reg, cmd_wdata, wb_dat_i, wb_ack_i,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_nack, rsp_timeout, busy,
               wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o
    );

endinterface

// File: rtl/i2c_wb_access.sv
// rtl/i2c_wb_access.sv - single outstanding Wishbone access; holds strobes until ack, drops them after
module i2c_wb_access (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       we,
    input  logic [2:0] adr,
    input  logic [7:0] wdata,
    output logic       done,
    output logic [7:0] rdata,
    output logic [2:0] wb_adr,
    output logic [7:0] wb_wdata,
    output logic       wb_we,
    output logic       wb_stb,
    output logic       wb_cyc,
    input  logic [7:0] wb_rdata,
    input  logic       wb_ack
);

    // The done cycle also blocks a restart, so a requester holding req for one extra
    // cycle while it advances does not launch a duplicate access.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_cyc   <= 1'b0;
            wb_we    <= 1'b0;
            wb_adr   <= '0;
            wb_wdata <= '0;
            done     <= 1'b0;
            rdata    <= '0;
        end else begin
            done <= 1'b0;
            if (wb_cyc) begin
                if (wb_ack) begin
                    wb_cyc   <= 1'b0;
                    wb_we    <= 1'b0;
                    wb_adr   <= '0;
                    wb_wdata <= '0;
                    done     <= 1'b1;
                    rdata    <= wb_rdata;
                end
            end else if (req && !done) begin
                wb_cyc   <= 1'b1;
                wb_we    <= we;
                wb_adr   <= adr;
                wb_wdata <= wdata;
            end
        end
    end

    assign wb_stb = wb_cyc;

endmodule

// File: rtl/i2c_reg_sequencer.sv
// rtl/i2c_reg_sequencer.sv - sequences one I2C register read/write through the core's Wishbone port
module i2c_reg_sequencer
    import i2c_reg_sequencer_pkg::*;
#(
    parameter logic [15:0] PRESCALE   = 16'd99,
    parameter logic [19:0] POLL_LIMIT = 20'hFFFFF
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    i2c_reg_sequencer_if.master bus
);

    state_t      state, state_next;
    cmd_t        cmd;
    logic [1:0]  phase;
    logic [1:0]  step;
    logic [19:0] poll_cnt;
    logic        stopping, nack_flag, timeout_flag;
    logic [7:0]  rsp_rdata_q;
    logic        rsp_nack_q, rsp_timeout_q;

    logic        req, acc_we, acc_done;
    logic [2:0]  acc_adr;
    logic [7:0]  acc_wdata, acc_rdata;
    logic        tip, rxack;

    assign tip   = acc_rdata[SR_TIP];
    assign rxack = acc_rdata[SR_RXACK];

    i2c_wb_access u_access (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .req      (req),
        .we       (acc_we),
        .adr      (acc_adr),
        .wdata    (acc_wdata),
        .done     (acc_done),
        .rdata    (acc_rdata),
        .wb_adr   (bus.wb_adr_o),
        .wb_wdata (bus.wb_dat_o),
        .wb_we    (bus.wb_we_o),
        .wb_stb   (bus.wb_stb_o),
        .wb_cyc   (bus.wb_cyc_o),
        .wb_rdata (bus.wb_dat_i),
        .wb_ack   (bus.wb_ack_i)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req        = 1'b0;
        acc_we     = 1'b0;
        acc_adr    = '0;
        acc_wdata  = '0;
        case (state)
            ST_INIT: begin
                req    = 1'b1;
                acc_we = 1'b1;
                case (step)
                    2'd0: begin
                        acc_adr   = ADR_PRER_LO;
                        acc_wdata = PRESCALE[7:0];
                    end
                    2'd1: begin
                        acc_adr   = ADR_PRER_HI;
                        acc_wdata = PRESCALE[15:8];
                    end
                    default: begin
                        acc_adr   = ADR_CTR;
                        acc_wdata = CTR_EN;
                    end
                endcase
                if (acc_done && step == 2'd2) state_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (bus.cmd_valid) state_next = ST_LOAD_TXR;
            end
            ST_LOAD_TXR: begin
                req       = 1'b1;
                acc_we    = 1'b1;
                acc_adr   = ADR_TXR;
                acc_wdata = phase_txr(cmd, phase);
                if (acc_done) state_next = ST_WRITE_CR;
            end
            ST_WRITE_CR: begin
                req       = 1'b1;
                acc_we    = 1'b1;
                acc_adr   = ADR_CR;
                acc_wdata = phase_cr(cmd, phase);
                if (acc_done) state_next = ST_POLL;
            end
            ST_POLL: begin
                req     = 1'b1;
                acc_adr = ADR_SR;
                if (acc_done) begin
                    if (tip) begin
                        if (poll_cnt + 20'd1 == POLL_LIMIT) state_next = ST_ABORT;
                    end else if (stopping) begin
                        state_next = ST_RESP;
                    end else if (phase == 2'd3) begin
                        state_next = ST_READ_RXR;
                    end else if (rxack) begin
                        state_next = ST_NACK_STOP;
                    end else if (phase == 2'd2) begin
                        // A write is finished here; a read skips TXR and issues the read CR.
                        state_next = cmd.rw ? ST_WRITE_CR : ST_RESP;
                    end else begin
                        state_next = ST_LOAD_TXR;
                    end
                end
            end
            ST_READ_RXR: begin
                req     = 1'b1;
                acc_adr = ADR_RXR;
                if (acc_done) state_next = ST_RESP;
            end
            ST_NACK_STOP: begin
                req       = 1'b1;
                acc_we    = 1'b1;
                acc_adr   = ADR_CR;
                acc_wdata = CR_STO;
                if (acc_done) state_next = ST_POLL;
            end
            ST_ABORT: begin
                req       = 1'b1;
                acc_we    = 1'b1;
                acc_adr   = ADR_CTR;
                acc_wdata = (step == 2'd0) ? CTR_OFF : CTR_EN;
                if (acc_done && step == 2'd1) state_next = ST_RESP;
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cmd           <= '0;
            phase         <= '0;
            step          <= '0;
            poll_cnt      <= '0;
            stopping      <= 1'b0;
            nack_flag     <= 1'b0;
            timeout_flag  <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_nack_q    <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            if (state == ST_IDLE && bus.cmd_valid) begin
                cmd          <= '{rw: bus.cmd_rw, dev: bus.cmd_dev, addr: bus.cmd_reg, wdata: bus.cmd_wdata};
                phase        <= 2'd0;
                stopping     <= 1'b0;
                nack_flag    <= 1'b0;
                timeout_flag <= 1'b0;
            end

            // Multi-write states (INIT, ABORT) walk their writes with step; every state entry restarts it.
            if (state != state_next) begin
                step <= 2'd0;
            end else if (acc_done) begin
                step <= step + 2'd1;
            end

            if (state != ST_POLL) begin
                poll_cnt <= '0;
            end else if (acc_done) begin
                poll_cnt <= poll_cnt + 20'd1;
            end

            if (state == ST_POLL && (state_next == ST_LOAD_TXR || state_next == ST_WRITE_CR)) begin
                phase <= phase + 2'd1;
            end

            if (state == ST_NACK_STOP) begin
                stopping  <= 1'b1;
                nack_flag <= 1'b1;
            end

            if (state == ST_POLL && state_next == ST_ABORT) begin
                timeout_flag <= 1'b1;
            end

            if (state_next == ST_RESP && state != ST_RESP) begin
                rsp_rdata_q   <= (state == ST_READ_RXR) ? acc_rdata : 8'h00;
                rsp_nack_q    <= nack_flag;
                rsp_timeout_q <= timeout_flag;
            end
        end
    end

    assign bus.cmd_ready   = (state == ST_IDLE);
    assign bus.busy        = (state != ST_IDLE);
    assign bus.rsp_valid   = (state == ST_RESP);
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_nack    = rsp_nack_q;
    assign bus.rsp_timeout = rsp_timeout_q;

endmodule
